// File: rtl/shiftregister_rotate_controller.sv
// Load/rotate sequencer for a WIDTH-bit circular right-shift register.
// Optional expected-copy checker enabled by defining SHIFTREG_CTRL_CHECK_EN.
module shiftregister_rotate_controller #(
    parameter int WIDTH = 5,
    parameter int STEPW = 5,
    localparam int PW   = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             clockpulse,
    input  logic             clear_,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] pattern,
    input  logic [STEPW-1:0] steps,
    input  logic [WIDTH-1:0] signal_q,
    output logic             preset_enable,
    output logic [WIDTH-1:0] preset,
    output logic             shift_enable,
    output logic             busy,
    output logic             done,
    output logic [PW-1:0]    position,
    output logic             error
);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    state_t           state, state_nxt;
    logic             accept;
    logic [STEPW-1:0] cnt;

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            IDLE:  if (start && !abort) begin
                       accept    = 1'b1;
                       state_nxt = LOAD;
                   end
            LOAD:  if (abort)              state_nxt = IDLE;
                   else if (cnt != '0)     state_nxt = SHIFT;
                   else                    state_nxt = DONE;
            SHIFT: if (abort)              state_nxt = IDLE;
                   else if (cnt == STEPW'(1)) state_nxt = DONE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Strobes are flopped from the next state so they line up exactly with state.
    always_ff @(posedge clockpulse or negedge clear_) begin
        if (!clear_) begin
            state         <= IDLE;
            preset        <= '0;
            cnt           <= '0;
            position      <= '0;
            preset_enable <= 1'b0;
            shift_enable  <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            state         <= state_nxt;
            preset_enable <= (state_nxt == LOAD);
            shift_enable  <= (state_nxt == SHIFT);
            busy          <= (state_nxt == LOAD) || (state_nxt == SHIFT);
            done          <= (state_nxt == DONE);
            if (accept) begin
                preset   <= pattern;
                cnt      <= steps;
                position <= '0;
            end else if (state == SHIFT) begin
                // The step in an aborted cycle still happened on the register.
                cnt      <= cnt - 1'b1;
                position <= (position == PW'(WIDTH-1)) ? '0 : position + 1'b1;
            end
        end
    end

`ifdef SHIFTREG_CTRL_CHECK_EN
    logic [WIDTH-1:0] exp_q;
    logic             chk_pend;

    // signal_q reflects a load/rotate one cycle after the strobe.
    always_ff @(posedge clockpulse or negedge clear_) begin
        if (!clear_) begin
            exp_q    <= '0;
            chk_pend <= 1'b0;
            error    <= 1'b0;
        end else begin
            chk_pend <= preset_enable | shift_enable;
            if (state == LOAD)
                exp_q <= preset;
            else if (state == SHIFT)
                exp_q <= {exp_q[0], exp_q[WIDTH-1:1]};
            if (accept)
                error <= 1'b0;
            else if (chk_pend && (signal_q != exp_q))
                error <= 1'b1;
        end
    end
`else
    logic unused_signal_q;
    assign unused_signal_q = ^signal_q;
    assign error           = 1'b0;
`endif

endmodule

// File: tb/tb_shiftregister_rotate_controller.sv
// Scoreboard bench: stimulus queues expected strobe cycles, a monitor pops and compares.
module tb_shiftregister_rotate_controller;

`ifdef SHIFTREG_CTRL_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic       clockpulse = 1'b0;
    logic       clear_     = 1'b0;
    logic       start      = 1'b0;
    logic       abort      = 1'b0;
    logic [4:0] pattern    = '0;
    logic [4:0] steps      = '0;
    logic [4:0] signal_q;
    logic       preset_enable, shift_enable, busy, done, error;
    logic [4:0] preset;
    logic [2:0] position;

    shiftregister_rotate_controller #(.WIDTH(5), .STEPW(5)) dut (
        .clockpulse(clockpulse), .clear_(clear_), .start(start), .abort(abort),
        .pattern(pattern), .steps(steps), .signal_q(signal_q),
        .preset_enable(preset_enable), .preset(preset), .shift_enable(shift_enable),
        .busy(busy), .done(done), .position(position), .error(error)
    );

    always #5 clockpulse = ~clockpulse;

    // Behavioural shift-register datapath, with an optional bit-0 fault after two shifts
    logic [4:0] mq = '0;
    int         nsh = 0;
    bit         fault_mode = 1'b0;
    always @(posedge clockpulse) begin
        if (preset_enable) begin
            mq  <= preset;
            nsh <= 0;
        end else if (shift_enable) begin
            mq  <= {mq[0], mq[4:1]};
            nsh <= nsh + 1;
        end
    end
    assign signal_q = mq ^ {4'b0, (fault_mode && nsh >= 2)};

    typedef struct {
        bit         pe, se, dn, bsy, err, chkq;
        logic [4:0] pre, q;
        logic [2:0] pos;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Queue n_ev strobe cycles of a run: LOAD, SHIFT x st, DONE (with final register/position).
    task automatic push_run(input logic [4:0] pat, input int st, input logic [4:0] fq,
                            input logic [2:0] fpos, input int err_from, input int n_ev);
        for (int k = 0; k < st + 2; k++) begin
            exp_t e;
            e = '{pe: 0, se: 0, dn: 0, bsy: 0, err: 0, chkq: 0, pre: pat, q: 0, pos: 0};
            if (k == 0) begin
                e.pe = 1; e.bsy = 1; e.pos = 0;
            end else if (k <= st) begin
                e.se = 1; e.bsy = 1; e.pos = 3'((k - 1) % 5);
            end else begin
                e.dn = 1; e.pos = fpos; e.chkq = 1; e.q = fq;
            end
            e.err = CHK && (k >= err_from);
            if (k < n_ev) sbq.push_back(e);
        end
    endtask

    task automatic start_run(input logic [4:0] pat, input logic [4:0] st);
        @(negedge clockpulse);
        pattern = pat; steps = st; start = 1'b1;
        @(posedge clockpulse); #1;
        start = 1'b0; pattern = ~pat; steps = 5'd0;
    endtask

    task automatic check_idle(input string name, input logic [2:0] pos);
        chk({name, "_flags"}, {busy, done, preset_enable, shift_enable}, 4'b0);
        chk({name, "_pos"}, position, pos);
    endtask

    always @(negedge clockpulse) begin
        if (clear_ && (preset_enable || shift_enable || done)) begin
            exp_t e;
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_strobe: got pe=%b se=%b done=%b expected none",
                         preset_enable, shift_enable, done);
            end else begin
                e = sbq.pop_front();
                if ({preset_enable, shift_enable, done, busy, error, preset, position} !==
                    {e.pe, e.se, e.dn, e.bsy, e.err, e.pre, e.pos}) begin
                    errors++;
                    $display("FAIL strobe_cycle: got pe=%b se=%b dn=%b busy=%b err=%b preset=%b pos=%0d expected pe=%b se=%b dn=%b busy=%b err=%b preset=%b pos=%0d",
                             preset_enable, shift_enable, done, busy, error, preset, position,
                             e.pe, e.se, e.dn, e.bsy, e.err, e.pre, e.pos);
                end
                if (e.chkq) chk("register_at_done", signal_q, e.q);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clockpulse);
        #1 chk("reset_outputs", {preset_enable, shift_enable, busy, done, error, preset, position}, '0);
        @(negedge clockpulse) clear_ = 1'b1;

        // Basic run: 11000 rotated right 3 -> 00011
        push_run(5'b11000, 3, 5'b00011, 3'd3, 99, 99);
        start_run(5'b11000, 5'd3);
        repeat (5) @(posedge clockpulse); #1;
        check_idle("run3", 3'd3);

        // Wrap: 7 steps, position 7 mod 5 = 2, 10000 -> 00100
        push_run(5'b10000, 7, 5'b00100, 3'd2, 99, 99);
        start_run(5'b10000, 5'd7);
        repeat (9) @(posedge clockpulse); #1;
        check_idle("wrap", 3'd2);

        // Zero steps: LOAD then DONE
        push_run(5'b10110, 0, 5'b10110, 3'd0, 99, 99);
        start_run(5'b10110, 5'd0);
        repeat (2) @(posedge clockpulse); #1;
        check_idle("zero", 3'd0);

        // Abort in the 2nd SHIFT cycle of a 5-step run
        push_run(5'b01101, 5, 5'b0, 3'd0, 99, 3);
        start_run(5'b01101, 5'd5);
        @(posedge clockpulse); #1;
        @(posedge clockpulse); #1;
        abort = 1'b1;
        @(posedge clockpulse); #1;
        abort = 1'b0;
        check_idle("abort", 3'd2);
        chk("abort_preset_hold", preset, 5'b01101);
        repeat (3) @(posedge clockpulse); #1;
        check_idle("abort_after", 3'd2);

        // start together with abort in IDLE: abort wins
        @(negedge clockpulse);
        start = 1'b1; abort = 1'b1; pattern = 5'b11111; steps = 5'd4;
        @(posedge clockpulse); #1;
        start = 1'b0; abort = 1'b0;
        check_idle("start_abort", 3'd2);

        // start while busy is ignored; 00111 -> 10011 -> 11001 -> 11100
        push_run(5'b00111, 3, 5'b11100, 3'd3, 99, 99);
        start_run(5'b00111, 5'd3);
        @(posedge clockpulse); #1;
        start = 1'b1; pattern = 5'b11111; steps = 5'd31;
        @(posedge clockpulse); #1;
        @(posedge clockpulse); #1;
        start = 1'b0;
        repeat (2) @(posedge clockpulse); #1;
        check_idle("busy_start", 3'd3);
        repeat (2) @(posedge clockpulse); #1;
        check_idle("busy_start_after", 3'd3);

        // Asynchronous reset mid-SHIFT
        push_run(5'b10101, 6, 5'b0, 3'd0, 99, 3);
        start_run(5'b10101, 5'd6);
        repeat (3) @(posedge clockpulse);
        #2 clear_ = 1'b0;
        #1 chk("async_reset_outputs", {preset_enable, shift_enable, busy, done, error, preset, position}, '0);
        chk("async_reset_queue", sbq.size(), 0);
        sbq.delete();
        @(negedge clockpulse) clear_ = 1'b1;
        @(posedge clockpulse); #1;
        check_idle("after_reset", 3'd0);

        // Checker: bit 0 forced wrong after the 2nd shift; 5 steps returns 11000, seen as 11001
        fault_mode = 1'b1;
        push_run(5'b11000, 5, 5'b11001, 3'd0, 4, 99);
        start_run(5'b11000, 5'd5);
        repeat (7) @(posedge clockpulse); #1;
        check_idle("fault_run", 3'd0);
        chk("error_sticky", error, CHK);
        fault_mode = 1'b0;
        repeat (2) @(posedge clockpulse); #1;
        chk("error_sticky_later", error, CHK);

        // Next accepted start clears error; 00001 -> 10000
        push_run(5'b00001, 1, 5'b10000, 3'd1, 99, 99);
        start_run(5'b00001, 5'd1);
        chk("error_cleared", error, 1'b0);
        repeat (3) @(posedge clockpulse); #1;
        check_idle("after_fault", 3'd1);

        for (int i = 0; i < 20 && sbq.size() != 0; i++) @(posedge clockpulse);
        chk("queue_drained", sbq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
